// File: rtl/receiver_mem_scheduler_if.sv
// receiver_mem_scheduler_if: requester handshakes and single-port memory bus
// shared between the receiver memory scheduler and its surroundings.
interface receiver_mem_scheduler_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              flush;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    modport master (
        output flush, wr_req, wr_data, rd_req, mem_rdata,
        input  wr_ack, rd_data, rd_valid, mem_addr, mem_wdata, mem_we, mem_re, count, full, empty
    );
    modport slave (
        input  flush, wr_req, wr_data, rd_req, mem_rdata,
        output wr_ack, rd_data, rd_valid, mem_addr, mem_wdata, mem_we, mem_re, count, full, empty
    );
endinterface

// File: rtl/receiver_mem_scheduler.sv
// receiver_mem_scheduler: round-robin sharing of a single-port receiver memory
// between a write requester and a read requester, with circular pointers.
module receiver_mem_scheduler #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input logic clk,
    input logic Reset,
    receiver_mem_scheduler_if.slave b
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, READ_WAIT} state_t;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    state_t            state;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              last_wr;
    logic              wr_ok, rd_ok, grant_wr;
    assign b.full   = b.count == FULL_CNT;
    assign b.empty  = b.count == '0;
    assign wr_ok    = b.wr_req && !b.full;
    assign rd_ok    = b.rd_req && !b.empty;
    // last_wr low after reset, so the first contention goes to the writer
    assign grant_wr = wr_ok && (!rd_ok || !last_wr);
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_wr     <= 1'b0;
            b.count     <= '0;
            b.mem_addr  <= '0;
            b.mem_wdata <= '0;
            b.mem_we    <= 1'b0;
            b.mem_re    <= 1'b0;
            b.wr_ack    <= 1'b0;
            b.rd_valid  <= 1'b0;
            b.rd_data   <= '0;
        end else begin
            b.rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (b.flush) begin
                        wr_ptr  <= '0;
                        rd_ptr  <= '0;
                        b.count <= '0;
                    end else if (grant_wr) begin
                        state       <= WRITE;
                        b.mem_addr  <= wr_ptr;
                        b.mem_wdata <= b.wr_data;
                        b.mem_we    <= 1'b1;
                        b.wr_ack    <= 1'b1;
                    end else if (rd_ok) begin
                        state      <= READ;
                        b.mem_addr <= rd_ptr;
                        b.mem_re   <= 1'b1;
                    end
                end
                WRITE: begin
                    state    <= IDLE;
                    b.mem_we <= 1'b0;
                    b.wr_ack <= 1'b0;
                    wr_ptr   <= wr_ptr == LAST_PTR ? '0 : wr_ptr + 1'b1;
                    b.count  <= b.count + 1'b1;
                    last_wr  <= 1'b1;
                end
                READ: begin
                    state    <= READ_WAIT;
                    b.mem_re <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    b.rd_data  <= DATA_W'(b.mem_rdata);
                    b.rd_valid <= 1'b1;
                    rd_ptr     <= rd_ptr == LAST_PTR ? '0 : rd_ptr + 1'b1;
                    b.count    <= b.count - 1'b1;
                    last_wr    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_receiver_mem_scheduler.sv
// tb_receiver_mem_scheduler: directed tests of the receiver memory scheduler
// against a behavioural 16x16 synchronous single-port memory.
module tb_receiver_mem_scheduler;
    logic clk = 1'b0;
    logic Reset = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [15:0] mem [16];

    receiver_mem_scheduler_if #(.DATA_W(16), .ADDR_W(4)) b();
    receiver_mem_scheduler #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dut (
        .clk(clk),
        .Reset(Reset),
        .b(b.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (b.mem_we) mem[b.mem_addr] <= b.mem_wdata;
        if (b.mem_re) b.mem_rdata <= mem[b.mem_addr];
    end

    task automatic wr_word(input logic [15:0] d, output logic acked);
        b.wr_req = 1'b1;
        b.wr_data = d;
        @(negedge clk);
        acked = b.wr_ack;
        b.wr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_word(output logic [15:0] d, output logic ok);
        b.rd_req = 1'b1;
        @(negedge clk);
        b.rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ok = b.rd_valid;
        d = b.rd_data;
    endtask

    task automatic do_flush();
        b.flush = 1'b1;
        @(negedge clk);
        b.flush = 1'b0;
    endtask

    task automatic test_reset();
        b.flush = 0; b.wr_req = 0; b.rd_req = 0; b.wr_data = 0; b.mem_rdata = 0;
        repeat (2) @(negedge clk);
        checks++; if (b.count !== 5'd0 || b.empty !== 1'b1 || b.full !== 1'b0) begin failures++; $display("FAIL reset_flags count=%0d empty=%b full=%b exp 0/1/0", b.count, b.empty, b.full); end
        checks++; if ({b.mem_we, b.mem_re, b.wr_ack, b.rd_valid} !== 4'b0 || b.mem_addr !== 4'd0 || b.rd_data !== 16'd0) begin failures++; $display("FAIL reset_outputs we/re/ack/valid=%b addr=%0d rd_data=%h exp 0", {b.mem_we, b.mem_re, b.wr_ack, b.rd_valid}, b.mem_addr, b.rd_data); end
        Reset = 1'b1;
        b.wr_req = 1'b1; b.wr_data = 16'h1234;
        @(negedge clk);
        checks++; if (b.mem_we !== 1'b1) begin failures++; $display("FAIL reset_pre_write mem_we=%b exp 1", b.mem_we); end
        #2 Reset = 1'b0;
        #1;
        checks++; if (b.mem_we !== 1'b0 || b.wr_ack !== 1'b0 || b.count !== 5'd0 || b.empty !== 1'b1) begin failures++; $display("FAIL reset_async we=%b ack=%b count=%0d empty=%b exp 0/0/0/1", b.mem_we, b.wr_ack, b.count, b.empty); end
        b.wr_req = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({b.mem_we, b.mem_re, b.wr_ack, b.rd_valid} !== 4'b0 || b.count !== 5'd0) begin failures++; $display("FAIL reset_no_spurious we/re/ack/valid=%b count=%0d exp 0", {b.mem_we, b.mem_re, b.wr_ack, b.rd_valid}, b.count); end
    endtask

    task automatic test_single();
        b.wr_req = 1'b1; b.wr_data = 16'hA5A5;
        @(negedge clk);
        checks++; if (b.mem_we !== 1'b1 || b.wr_ack !== 1'b1 || b.mem_addr !== 4'd0 || b.mem_wdata !== 16'hA5A5) begin failures++; $display("FAIL single_write we=%b ack=%b addr=%0d wdata=%h exp 1/1/0/a5a5", b.mem_we, b.wr_ack, b.mem_addr, b.mem_wdata); end
        b.wr_req = 1'b0;
        @(negedge clk);
        checks++; if (b.count !== 5'd1 || b.wr_ack !== 1'b0 || b.empty !== 1'b0) begin failures++; $display("FAIL single_count count=%0d ack=%b empty=%b exp 1/0/0", b.count, b.wr_ack, b.empty); end
        b.rd_req = 1'b1;
        @(negedge clk);
        checks++; if (b.mem_re !== 1'b1 || b.mem_addr !== 4'd0) begin failures++; $display("FAIL single_read_issue re=%b addr=%0d exp 1/0", b.mem_re, b.mem_addr); end
        b.rd_req = 1'b0;
        @(negedge clk);
        checks++; if (b.rd_valid !== 1'b0 || b.mem_re !== 1'b0) begin failures++; $display("FAIL single_read_wait valid=%b re=%b exp 0/0", b.rd_valid, b.mem_re); end
        @(negedge clk);
        checks++; if (b.rd_valid !== 1'b1 || b.rd_data !== 16'hA5A5 || b.count !== 5'd0 || b.empty !== 1'b1) begin failures++; $display("FAIL single_read_data valid=%b data=%h count=%0d empty=%b exp 1/a5a5/0/1", b.rd_valid, b.rd_data, b.count, b.empty); end
        @(negedge clk);
        checks++; if (b.rd_valid !== 1'b0 || b.rd_data !== 16'hA5A5) begin failures++; $display("FAIL single_read_hold valid=%b data=%h exp 0/a5a5", b.rd_valid, b.rd_data); end
    endtask

    task automatic test_fill_wrap();
        logic ack, ok, seen;
        logic [15:0] d;
        do_flush();
        for (int i = 0; i < 16; i++) begin
            wr_word(16'(i), ack);
            checks++; if (ack !== 1'b1) begin failures++; $display("FAIL fill_ack word=%0d ack=%b exp 1", i, ack); end
        end
        checks++; if (b.full !== 1'b1 || b.count !== 5'd16) begin failures++; $display("FAIL fill_full full=%b count=%0d exp 1/16", b.full, b.count); end
        b.wr_req = 1'b1; b.wr_data = 16'hDEAD;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (b.wr_ack || b.mem_we) seen = 1'b1;
        end
        b.wr_req = 1'b0;
        checks++; if (seen !== 1'b0 || b.count !== 5'd16) begin failures++; $display("FAIL fill_blocked ack_seen=%b count=%0d exp 0/16", seen, b.count); end
        rd_word(d, ok);
        checks++; if (ok !== 1'b1 || d !== 16'h0000) begin failures++; $display("FAIL fill_first_read valid=%b data=%h exp 1/0000", ok, d); end
        b.wr_req = 1'b1; b.wr_data = 16'h0010;
        @(negedge clk);
        checks++; if (b.wr_ack !== 1'b1 || b.mem_addr !== 4'd0) begin failures++; $display("FAIL wrap_write_addr ack=%b addr=%0d exp 1/0", b.wr_ack, b.mem_addr); end
        b.wr_req = 1'b0;
        @(negedge clk);
        checks++; if (mem[0] !== 16'h0010) begin failures++; $display("FAIL wrap_mem0 got=%h exp 0010", mem[0]); end
        for (int i = 1; i <= 16; i++) begin
            rd_word(d, ok);
            checks++; if (ok !== 1'b1 || d !== 16'(i)) begin failures++; $display("FAIL drain_order idx=%0d valid=%b data=%h exp %h", i, ok, d, 16'(i)); end
        end
        checks++; if (b.empty !== 1'b1 || b.count !== 5'd0) begin failures++; $display("FAIL drain_empty empty=%b count=%0d exp 1/0", b.empty, b.count); end
    endtask

    task automatic test_contention();
        logic ack, ok, bad;
        logic [15:0] d;
        logic [5:0] seq;
        logic [15:0] rdv [3];
        int ng, nr;
        for (int i = 0; i < 5; i++) wr_word(16'h0100 + 16'(i), ack);
        rd_word(d, ok);
        checks++; if (b.count !== 5'd4 || d !== 16'h0100) begin failures++; $display("FAIL cont_setup count=%0d data=%h exp 4/0100", b.count, d); end
        seq = '0; ng = 0; nr = 0; bad = 1'b0;
        rdv[0] = 0; rdv[1] = 0; rdv[2] = 0;
        b.wr_req = 1'b1; b.rd_req = 1'b1; b.wr_data = 16'h0200;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b.mem_we || b.mem_re) begin
                if (ng < 6) seq[ng] = b.mem_we;
                ng++;
                if (ng == 6) begin b.wr_req = 1'b0; b.rd_req = 1'b0; end
            end
            if (b.rd_valid) begin
                if (nr < 3) rdv[nr] = b.rd_data;
                nr++;
            end
            if (b.count < 5'd4 || b.count > 5'd5) bad = 1'b1;
        end
        b.wr_req = 1'b0; b.rd_req = 1'b0;
        checks++; if (ng != 6 || seq !== 6'b010101) begin failures++; $display("FAIL cont_order grants=%0d seq=%b exp 6/010101", ng, seq); end
        checks++; if (bad !== 1'b0 || b.count !== 5'd4) begin failures++; $display("FAIL cont_count out_of_range=%b count=%0d exp 0/4", bad, b.count); end
        checks++; if (nr != 3 || rdv[0] !== 16'h0101 || rdv[1] !== 16'h0102 || rdv[2] !== 16'h0103) begin failures++; $display("FAIL cont_rdata n=%0d d=%h %h %h exp 3 0101 0102 0103", nr, rdv[0], rdv[1], rdv[2]); end
    endtask

    task automatic test_blocking();
        logic ack, ok, seen;
        logic [15:0] d;
        do_flush();
        checks++; if (b.count !== 5'd0 || b.empty !== 1'b1) begin failures++; $display("FAIL flush_to_empty count=%0d empty=%b exp 0/1", b.count, b.empty); end
        b.rd_req = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (b.mem_re || b.rd_valid) seen = 1'b1;
        end
        b.rd_req = 1'b0;
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL empty_block mem_re_seen=%b exp 0", seen); end
        for (int i = 0; i < 7; i++) wr_word(16'h0300 + 16'(i), ack);
        checks++; if (b.count !== 5'd7) begin failures++; $display("FAIL flush_pre count=%0d exp 7", b.count); end
        do_flush();
        checks++; if (b.count !== 5'd0 || b.empty !== 1'b1) begin failures++; $display("FAIL flush_idle count=%0d empty=%b exp 0/1", b.count, b.empty); end
        b.wr_req = 1'b1; b.wr_data = 16'hBEEF;
        @(negedge clk);
        checks++; if (b.wr_ack !== 1'b1 || b.mem_addr !== 4'd0) begin failures++; $display("FAIL flush_wr_ptr ack=%b addr=%0d exp 1/0", b.wr_ack, b.mem_addr); end
        b.wr_req = 1'b0;
        @(negedge clk);
        b.rd_req = 1'b1;
        @(negedge clk);
        checks++; if (b.mem_re !== 1'b1 || b.mem_addr !== 4'd0) begin failures++; $display("FAIL flush_rd_ptr re=%b addr=%0d exp 1/0", b.mem_re, b.mem_addr); end
        b.rd_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (b.rd_valid !== 1'b1 || b.rd_data !== 16'hBEEF) begin failures++; $display("FAIL flush_readback valid=%b data=%h exp 1/beef", b.rd_valid, b.rd_data); end
    endtask

    task automatic test_flush_busy();
        logic ack;
        wr_word(16'h0011, ack);
        wr_word(16'h0022, ack);
        b.rd_req = 1'b1;
        @(negedge clk);
        b.rd_req = 1'b0;
        @(negedge clk);
        b.flush = 1'b1;
        @(negedge clk);
        checks++; if (b.rd_valid !== 1'b1 || b.rd_data !== 16'h0011 || b.count !== 5'd1) begin failures++; $display("FAIL flush_rw_complete valid=%b data=%h count=%0d exp 1/0011/1", b.rd_valid, b.rd_data, b.count); end
        @(negedge clk);
        b.flush = 1'b0;
        checks++; if (b.count !== 5'd0 || b.empty !== 1'b1) begin failures++; $display("FAIL flush_after_idle count=%0d empty=%b exp 0/1", b.count, b.empty); end
        wr_word(16'h0033, ack);
        wr_word(16'h0044, ack);
        b.rd_req = 1'b1;
        @(negedge clk);
        b.rd_req = 1'b0;
        b.flush = 1'b1;
        @(negedge clk);
        b.flush = 1'b0;
        @(negedge clk);
        checks++; if (b.rd_valid !== 1'b1 || b.rd_data !== 16'h0033 || b.count !== 5'd1) begin failures++; $display("FAIL flush_ignored valid=%b data=%h count=%0d exp 1/0033/1", b.rd_valid, b.rd_data, b.count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_wrap();
        test_contention();
        test_blocking();
        test_flush_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
